// File: rtl/instr_enc_pkg.sv
// rtl/instr_enc_pkg.sv - mnemonic codes, MIPS opcode/funct constants and FSM states
package instr_enc_pkg;

   typedef enum logic [5:0] {
      MN_NOP   = 6'd0,
      MN_ADD   = 6'd1,  MN_ADDU  = 6'd2,  MN_SUB   = 6'd3,  MN_SUBU  = 6'd4,
      MN_AND   = 6'd5,  MN_OR    = 6'd6,  MN_XOR   = 6'd7,  MN_NOR   = 6'd8,
      MN_SLT   = 6'd9,  MN_SLTU  = 6'd10, MN_SLL   = 6'd11, MN_SRL   = 6'd12,
      MN_SRA   = 6'd13, MN_SLLV  = 6'd14, MN_SRLV  = 6'd15, MN_SRAV  = 6'd16,
      MN_JR    = 6'd17, MN_JALR  = 6'd18, MN_BGEZ  = 6'd19, MN_BLTZ  = 6'd20,
      MN_J     = 6'd21, MN_JAL   = 6'd22, MN_BEQ   = 6'd23, MN_BNE   = 6'd24,
      MN_BLEZ  = 6'd25, MN_BGTZ  = 6'd26, MN_ADDI  = 6'd27, MN_ADDIU = 6'd28,
      MN_SLTI  = 6'd29, MN_SLTIU = 6'd30, MN_ANDI  = 6'd31, MN_ORI   = 6'd32,
      MN_XORI  = 6'd33, MN_LUI   = 6'd34, MN_LB    = 6'd35, MN_LH    = 6'd36,
      MN_LW    = 6'd37, MN_LBU   = 6'd38, MN_LHU   = 6'd39, MN_SB    = 6'd40,
      MN_SH    = 6'd41, MN_SW    = 6'd42
   } mnem_t;

   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

   localparam logic [4:0] R0 = 5'd0, R1 = 5'd1, R31 = 5'd31;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_t;

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
      return {OP_SPECIAL, rs, rt, rd, shamt, funct};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// rtl/instr_field_pack.sv - combinational mnemonic-to-MIPS-word packing with illegal flag
module instr_field_pack
   import instr_enc_pkg::*;
(
   input  logic [5:0]  mnem,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word    = 32'h0;
      illegal = 1'b0;
      case (mnem)
         MN_NOP:   word = 32'h0;
         MN_ADD:   word = rtype(rs, rt, rd, R0, FN_ADD);
         MN_ADDU:  word = rtype(rs, rt, rd, R0, FN_ADDU);
         MN_SUB:   word = rtype(rs, rt, rd, R0, FN_SUB);
         MN_SUBU:  word = rtype(rs, rt, rd, R0, FN_SUBU);
         MN_AND:   word = rtype(rs, rt, rd, R0, FN_AND);
         MN_OR:    word = rtype(rs, rt, rd, R0, FN_OR);
         MN_XOR:   word = rtype(rs, rt, rd, R0, FN_XOR);
         MN_NOR:   word = rtype(rs, rt, rd, R0, FN_NOR);
         MN_SLT:   word = rtype(rs, rt, rd, R0, FN_SLT);
         MN_SLTU:  word = rtype(rs, rt, rd, R0, FN_SLTU);
         MN_SLL:   word = rtype(R0, rt, rd, shamt, FN_SLL);
         MN_SRL:   word = rtype(R0, rt, rd, shamt, FN_SRL);
         MN_SRA:   word = rtype(R0, rt, rd, shamt, FN_SRA);
         // Variable shifts carry the amount register in rs.
         MN_SLLV:  word = rtype(rs, rt, rd, R0, FN_SLLV);
         MN_SRLV:  word = rtype(rs, rt, rd, R0, FN_SRLV);
         MN_SRAV:  word = rtype(rs, rt, rd, R0, FN_SRAV);
         MN_JR:    word = rtype(rs, R0, R0, R0, FN_JR);
         MN_JALR:  word = rtype(rs, R0, (rd == R0) ? R31 : rd, R0, FN_JALR);
         MN_BGEZ:  word = itype(OP_REGIMM, rs, R1, imm);
         MN_BLTZ:  word = itype(OP_REGIMM, rs, R0, imm);
         MN_BLEZ:  word = itype(OP_BLEZ, rs, R0, imm);
         MN_BGTZ:  word = itype(OP_BGTZ, rs, R0, imm);
         MN_J:     word = {OP_J, target};
         MN_JAL:   word = {OP_JAL, target};
         MN_BEQ:   word = itype(OP_BEQ, rs, rt, imm);
         MN_BNE:   word = itype(OP_BNE, rs, rt, imm);
         MN_ADDI:  word = itype(OP_ADDI, rs, rt, imm);
         MN_ADDIU: word = itype(OP_ADDIU, rs, rt, imm);
         MN_SLTI:  word = itype(OP_SLTI, rs, rt, imm);
         MN_SLTIU: word = itype(OP_SLTIU, rs, rt, imm);
         MN_ANDI:  word = itype(OP_ANDI, rs, rt, imm);
         MN_ORI:   word = itype(OP_ORI, rs, rt, imm);
         MN_XORI:  word = itype(OP_XORI, rs, rt, imm);
         MN_LUI:   word = itype(OP_LUI, R0, rt, imm);
         MN_LB:    word = itype(OP_LB, rs, rt, imm);
         MN_LH:    word = itype(OP_LH, rs, rt, imm);
         MN_LW:    word = itype(OP_LW, rs, rt, imm);
         MN_LBU:   word = itype(OP_LBU, rs, rt, imm);
         MN_LHU:   word = itype(OP_LHU, rs, rt, imm);
         MN_SB:    word = itype(OP_SB, rs, rt, imm);
         MN_SH:    word = itype(OP_SH, rs, rt, imm);
         MN_SW:    word = itype(OP_SW, rs, rt, imm);
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - load-session FSM writing encoded MIPS words into instruction memory
module instr_encoder
   import instr_enc_pkg::*;
#(
   parameter int IM_AW     = 10,
   parameter int BASE_ADDR = 0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             finish,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_mnem,
   input  logic [4:0]       in_rs,
   input  logic [4:0]       in_rt,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_shamt,
   input  logic [15:0]      in_imm,
   input  logic [25:0]      in_target,
   output logic             im_we,
   output logic [IM_AW-1:0] im_addr,
   output logic [31:0]      im_wdata,
   output logic             cpu_hold,
   output logic             busy,
   output logic             err_illegal,
   output logic             err_full,
   output logic [IM_AW:0]   count
);

   localparam logic [IM_AW:0]   CAPACITY = {1'b1, {IM_AW{1'b0}}};
   localparam logic [IM_AW-1:0] BASE     = IM_AW'(BASE_ADDR);

   state_t      state;
   logic [31:0] packed_word;
   logic        illegal;
   logic        full;
   logic        accept;

   instr_field_pack u_pack (
      .mnem    (in_mnem),
      .rs      (in_rs),
      .rt      (in_rt),
      .rd      (in_rd),
      .shamt   (in_shamt),
      .imm     (in_imm),
      .target  (in_target),
      .word    (packed_word),
      .illegal (illegal)
   );

   // The word in flight counts against capacity so the last slot is never overbooked.
   assign full     = (count + {{IM_AW{1'b0}}, im_we}) >= CAPACITY;
   // The output register drains every cycle, so it never blocks acceptance.
   assign in_ready = (state == ST_LOAD) && !full;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         im_we       <= 1'b0;
         im_addr     <= BASE;
         im_wdata    <= 32'h0;
         cpu_hold    <= 1'b1;
         busy        <= 1'b0;
         err_illegal <= 1'b0;
         err_full    <= 1'b0;
         count       <= '0;
      end else begin
         im_we <= accept && !illegal;
         if (accept && !illegal)
            im_wdata <= packed_word;
         if (im_we) begin
            im_addr <= im_addr + IM_AW'(1);
            count   <= count + (IM_AW+1)'(1);
         end
         if (accept && illegal)
            err_illegal <= 1'b1;
         if ((state == ST_LOAD) && full && in_valid)
            err_full <= 1'b1;

         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state       <= ST_LOAD;
                  count       <= '0;
                  im_addr     <= BASE;
                  err_illegal <= 1'b0;
                  err_full    <= 1'b0;
                  cpu_hold    <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (finish)
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               // Nothing is accepted here, so the pending word is written this cycle.
               state    <= ST_DONE;
               cpu_hold <= 1'b0;
               busy     <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder with a table-driven encoding model
module tb_instr_encoder;
   import instr_enc_pkg::*;

   localparam int AW = 2;

   localparam int K_ILL = 0, K_NOP = 1, K_R = 2, K_SH = 3, K_JR = 4, K_JALR = 5;
   localparam int K_I = 6, K_LUI = 7, K_BZ = 8, K_J = 9;

   typedef struct {
      logic [5:0]  mn;
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      logic [25:0] tg;
   } desc_t;

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, finish = 1'b0, in_valid = 1'b0;
   logic          in_ready;
   logic [5:0]    in_mnem = '0;
   logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
   logic [15:0]   in_imm = '0;
   logic [25:0]   in_target = '0;
   logic          im_we, cpu_hold, busy, err_illegal, err_full;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_wdata;
   logic [AW:0]   count;

   int errors = 0, checks = 0, cyc = 0;
   int kind_t[64], code_t[64], rtv_t[64];
   logic [AW-1:0] wa_q[$];
   logic [31:0]   wd_q[$];
   int            wc_q[$];

   instr_encoder #(.IM_AW(AW), .BASE_ADDR(0)) dut (
      .clk(clk), .rst(rst), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_imm(in_imm), .in_target(in_target),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .err_illegal(err_illegal),
      .err_full(err_full), .count(count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (im_we) begin
         wa_q.push_back(im_addr);
         wd_q.push_back(im_wdata);
         wc_q.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic put(input int mn, input int k, input int c, input int rv);
      kind_t[mn] = k; code_t[mn] = c; rtv_t[mn] = rv;
   endtask

   task automatic build_table();
      for (int i = 0; i < 64; i++) put(i, K_ILL, 0, 0);
      put(MN_NOP, K_NOP, 0, 0);
      put(MN_ADD, K_R, 'h20, 0);  put(MN_ADDU, K_R, 'h21, 0); put(MN_SUB, K_R, 'h22, 0);
      put(MN_SUBU, K_R, 'h23, 0); put(MN_AND, K_R, 'h24, 0);  put(MN_OR, K_R, 'h25, 0);
      put(MN_XOR, K_R, 'h26, 0);  put(MN_NOR, K_R, 'h27, 0);  put(MN_SLT, K_R, 'h2A, 0);
      put(MN_SLTU, K_R, 'h2B, 0); put(MN_SLLV, K_R, 'h04, 0); put(MN_SRLV, K_R, 'h06, 0);
      put(MN_SRAV, K_R, 'h07, 0); put(MN_SLL, K_SH, 'h00, 0); put(MN_SRL, K_SH, 'h02, 0);
      put(MN_SRA, K_SH, 'h03, 0); put(MN_JR, K_JR, 'h08, 0);  put(MN_JALR, K_JALR, 'h09, 0);
      put(MN_BGEZ, K_BZ, 'h01, 1); put(MN_BLTZ, K_BZ, 'h01, 0);
      put(MN_BLEZ, K_BZ, 'h06, 0); put(MN_BGTZ, K_BZ, 'h07, 0);
      put(MN_J, K_J, 'h02, 0);    put(MN_JAL, K_J, 'h03, 0);  put(MN_LUI, K_LUI, 'h0F, 0);
      put(MN_BEQ, K_I, 'h04, 0);  put(MN_BNE, K_I, 'h05, 0);  put(MN_ADDI, K_I, 'h08, 0);
      put(MN_ADDIU, K_I, 'h09, 0); put(MN_SLTI, K_I, 'h0A, 0); put(MN_SLTIU, K_I, 'h0B, 0);
      put(MN_ANDI, K_I, 'h0C, 0); put(MN_ORI, K_I, 'h0D, 0);  put(MN_XORI, K_I, 'h0E, 0);
      put(MN_LB, K_I, 'h20, 0);   put(MN_LH, K_I, 'h21, 0);   put(MN_LW, K_I, 'h23, 0);
      put(MN_LBU, K_I, 'h24, 0);  put(MN_LHU, K_I, 'h25, 0);  put(MN_SB, K_I, 'h28, 0);
      put(MN_SH, K_I, 'h29, 0);   put(MN_SW, K_I, 'h2B, 0);
   endtask

   task automatic model(input desc_t d, output logic [31:0] w, output bit ill);
      int k, c, rd_eff;
      k = kind_t[d.mn]; c = code_t[d.mn];
      ill = (k == K_ILL);
      rd_eff = (d.rd == 0) ? 31 : int'(d.rd);
      case (k)
         K_R:    w = c + (32'(d.rd) << 11) + (32'(d.rt) << 16) + (32'(d.rs) << 21);
         K_SH:   w = c + (32'(d.sh) << 6) + (32'(d.rd) << 11) + (32'(d.rt) << 16);
         K_JR:   w = c + (32'(d.rs) << 21);
         K_JALR: w = c + (32'(rd_eff) << 11) + (32'(d.rs) << 21);
         K_I:    w = (32'(c) << 26) + (32'(d.rs) << 21) + (32'(d.rt) << 16) + 32'(d.imm);
         K_LUI:  w = (32'(c) << 26) + (32'(d.rt) << 16) + 32'(d.imm);
         K_BZ:   w = (32'(c) << 26) + (32'(d.rs) << 21) + (32'(rtv_t[d.mn]) << 16) + 32'(d.imm);
         K_J:    w = (32'(c) << 26) + 32'(d.tg);
         default: w = 32'h0;
      endcase
   endtask

   function automatic desc_t mk(input int mn, input int rs, input int rt, input int rd,
                                input int sh, input int imm, input int tg);
      desc_t d;
      d.mn = 6'(mn); d.rs = 5'(rs); d.rt = 5'(rt); d.rd = 5'(rd);
      d.sh = 5'(sh); d.imm = 16'(imm); d.tg = 26'(tg);
      return d;
   endfunction

   task automatic apply(input desc_t d);
      in_mnem = d.mn; in_rs = d.rs; in_rt = d.rt; in_rd = d.rd;
      in_shamt = d.sh; in_imm = d.imm; in_target = d.tg;
   endtask

   task automatic send(input desc_t d, input logic fin);
      int n = 0;
      @(negedge clk);
      apply(d);
      in_valid = 1'b1;
      finish = fin;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      finish = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      wa_q.delete(); wd_q.delete(); wc_q.delete();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic finish_alone();
      @(negedge clk);
      finish = 1'b1;
      @(posedge clk);
      #1 finish = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_writes(input string tag, input logic [31:0] exp_w[$]);
      chk({tag, "_nwrites"}, wd_q.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < wd_q.size(); i++) begin
         chk({tag, "_addr"}, 32'(wa_q[i]), 32'(i));
         chk({tag, "_word"}, wd_q[i], exp_w[i]);
      end
   endtask

   task automatic run_random(input int s);
      desc_t d;
      logic [31:0] exp_w[$];
      logic [31:0] w;
      bit ill, any_ill;
      int nleg, nill, tot;
      any_ill = 0;
      nleg = $urandom_range(1, 4);
      nill = $urandom_range(0, 1);
      tot = nleg + nill;
      pulse_start();
      for (int k = 0; k < tot; k++) begin
         d.mn  = (nill == 1 && k == 1) ? 6'($urandom_range(43, 63)) : 6'($urandom_range(0, 42));
         d.rs  = 5'($urandom); d.rt = 5'($urandom); d.rd = 5'($urandom);
         d.sh  = 5'($urandom); d.imm = 16'($urandom); d.tg = 26'($urandom);
         if ($urandom_range(0, 3) == 0) d.rd = 5'd0;
         model(d, w, ill);
         if (ill) any_ill = 1; else exp_w.push_back(w);
         idle($urandom_range(0, 2));
         send(d, (k == tot - 1) && (s % 2 == 1));
      end
      if (s % 2 == 0) finish_alone();
      idle(3);
      check_writes("rand", exp_w);
      chk("rand_count", 32'(count), 32'(exp_w.size()));
      chk("rand_err_illegal", err_illegal, any_ill);
      chk("rand_cpu_hold", cpu_hold, 1'b0);
   endtask

   initial begin
      logic [31:0] exp_w[$];
      build_table();

      // Reset values
      idle(2);
      chk("rst_we", im_we, 1'b0);
      chk("rst_addr", 32'(im_addr), 32'd0);
      chk("rst_hold", cpu_hold, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_errs", {err_illegal, err_full}, 2'b00);
      chk("rst_ready", in_ready, 1'b0);
      rst = 1'b0;
      idle(1);
      chk("idle_hold", cpu_hold, 1'b1);

      // addi then add, back to back
      pulse_start();
      chk("load_busy", busy, 1'b1);
      send(mk(MN_ADDI, 0, 8, 0, 0, 5, 0), 1'b0);
      send(mk(MN_ADD, 1, 2, 3, 0, 0, 0), 1'b0);
      finish_alone();
      idle(3);
      exp_w = '{32'h20080005, 32'h00221820};
      check_writes("s1", exp_w);
      if (wc_q.size() == 2) chk("s1_consecutive", wc_q[1] - wc_q[0], 1);
      chk("s1_count", 32'(count), 32'd2);
      chk("s1_hold", cpu_hold, 1'b0);
      chk("s1_busy", busy, 1'b0);

      // Mixed formats, finish with the last descriptor
      pulse_start();
      send(mk(MN_LUI, 9, 1, 0, 0, 'h1234, 0), 1'b0);
      send(mk(MN_J, 0, 0, 0, 0, 0, 'h10), 1'b0);
      send(mk(MN_BGEZ, 4, 0, 0, 0, 'hFFFE, 0), 1'b0);
      send(mk(MN_SLL, 7, 1, 2, 4, 0, 0), 1'b1);
      @(negedge clk);
      chk("end_we", im_we, 1'b1);
      chk("end_hold_during_we", cpu_hold, 1'b1);
      @(negedge clk);
      chk("end_we_off", im_we, 1'b0);
      chk("end_hold_fall", cpu_hold, 1'b0);
      chk("end_busy", busy, 1'b0);
      exp_w = '{32'h3C011234, 32'h08000010, 32'h0481FFFE, 32'h00011100};
      check_writes("s2", exp_w);
      chk("s2_count", 32'(count), 32'd4);

      // Illegal mnemonic mid-stream
      pulse_start();
      chk("s3_err_cleared", {err_illegal, err_full}, 2'b00);
      send(mk(MN_ADD, 1, 2, 3, 0, 0, 0), 1'b0);
      send(mk(6'h3F, 1, 2, 3, 0, 0, 0), 1'b0);
      send(mk(MN_SUB, 4, 5, 6, 0, 0, 0), 1'b1);
      idle(3);
      exp_w = '{32'h00221820, 32'h00853022};
      check_writes("s3", exp_w);
      chk("s3_err_illegal", err_illegal, 1'b1);
      chk("s3_count", 32'(count), 32'd2);

      // Memory full: fifth descriptor is refused
      pulse_start();
      for (int i = 0; i < 4; i++) send(mk(MN_ORI, i, i + 1, 0, 0, i * 3, 0), 1'b0);
      @(negedge clk);
      apply(mk(MN_ORI, 9, 9, 0, 0, 9, 0));
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("full_ready", in_ready, 1'b0);
         @(negedge clk);
      end
      chk("full_err", err_full, 1'b1);
      chk("full_count", 32'(count), 32'd4);
      in_valid = 1'b0;
      finish_alone();
      idle(2);
      exp_w = '{32'h34010000, 32'h34220003, 32'h34430006, 32'h34640009};
      check_writes("s4", exp_w);

      // Randomized sessions against the model
      for (int s = 0; s < 8; s++) run_random(s);

      // Reset mid-session during back-to-back writes
      pulse_start();
      send(mk(MN_ADDU, 1, 1, 1, 0, 0, 0), 1'b0);
      send(mk(MN_ADDU, 2, 2, 2, 0, 0, 0), 1'b0);
      @(negedge clk);
      apply(mk(MN_ADDU, 3, 3, 3, 0, 0, 0));
      in_valid = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("rstmid_hold", cpu_hold, 1'b1);
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_count", 32'(count), 32'd0);
      chk("rstmid_addr", 32'(im_addr), 32'd0);
      idle(2);
      rst = 1'b0;
      idle(2);
      chk("rstmid_nwrites", wd_q.size(), 2);
      chk("rstmid_we", im_we, 1'b0);
      chk("rstmid_ready", in_ready, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart to the CPU control decoder. Accepts symbolic instruction descriptors (mnemonic plus fields) over a valid/ready stream and emits standard MIPS 32-bit instruction words.
- Writes each word sequentially into instruction memory through a word-addressed write port.
- Holds the CPU in reset while a program load is in progress.
- Used for bench program loading and on-board debug injection.

Parameters:
- IM_AW, 10, instruction-memory word-address width; capacity is 2**IM_AW words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session at BASE_ADDR.
- finish  in  1  one-cycle pulse; ends the session after the pending word drains.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  encoder can accept a descriptor.
- in_mnem  in  6  mnemonic code (MN_* enum).
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target.
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  IM_AW  word address.
- im_wdata  out  32  encoded word.
- cpu_hold  out  1  CPU reset request.
- busy  out  1  session active.
- err_illegal  out  1  sticky; an undefined mnemonic was received.
- err_full  out  1  sticky; a descriptor arrived with memory full.
- count  out  IM_AW+1  number of words written this session.

Behaviour:
- Reset values: state IDLE, all outputs 0, im_addr = BASE_ADDR, except cpu_hold = 1.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE --start--> LOAD. On this transition: clear count and both error flags, set address to BASE_ADDR, keep cpu_hold high.
  - LOAD --finish--> DRAIN.
  - DRAIN --output register empty--> DONE.
  - DONE: cpu_hold = 0, busy = 0. start returns to LOAD.
- cpu_hold is 1 in IDLE, LOAD and DRAIN, and 0 only in DONE.
- Handshake: a transfer occurs when in_valid & in_ready.
  - in_ready = (state == LOAD) & !full & (output register empty | written this cycle).
  - Data fields must be stable while in_valid is high.
- Latency: one-stage pipeline. A descriptor accepted at edge N has im_we = 1 with its word during cycle N+1. Back-to-back sustained throughput is 1 word/clock.
- Address and count: both advance by 1 on each im_we. full = (count == 2**IM_AW). The address is not wrapped.
  - In LOAD with full, in_ready = 0. If in_valid is held for 1 cycle in that state, set err_full; no write occurs.
- Encoding:
  - R-type: {6'h00, rs, rt, rd, shamt, funct}.
  - I-type: {op, rs, rt, imm}.
  - J-type: {op, target}.
- Field masking:
  - Shifts sll/srl/sra force rs = 0.
  - sllv/srlv/srav use the rs field as the shift amount and force shamt = 0.
  - jr forces rt = rd = shamt = 0.
  - jalr with rd = 0 encodes rd = 31.
  - lui forces rs = 0.
  - bgez/bltz/bgtz/blez force the rt field to 1/0/0/0 respectively.
  - For all other mnemonics, unused fields are forced to 0.
- Funct codes: add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B, sll 00, srl 02, sra 03, sllv 04, srlv 06, srav 07, jr 08, jalr 09.
- Opcodes: bgez/bltz 01, j 02, jal 03, beq 04, bne 05, blez 06, bgtz 07, addi 08, addiu 09, slti 0A, sltiu 0B, andi 0C, ori 0D, xori 0E, lui 0F, lb 20, lh 21, lw 23, lbu 24, lhu 25, sb 28, sh 29, sw 2B.
- Illegal mnemonic: the descriptor is consumed but not written; set err_illegal. count and address are unchanged.
- Simultaneous start and finish: start wins.
- finish outside LOAD is ignored.
- start during LOAD or DRAIN is ignored.
- finish and acceptance in the same cycle: the descriptor is accepted; the FSM enters DRAIN.
- rst mid-session: abort immediately. Any pending word is dropped with no im_we; return to the reset values.

Decomposition:
- Package instr_enc_pkg holds:
  - MN_* mnemonic enum (6-bit; MN_NOP = 0 encodes 32'h0).
  - OP_* and FN_* constants.
  - state encoding.
- Sub-module instr_field_pack: purely combinational mnemonic-to-word packing with an illegal flag.
- Top level holds the FSM, pipeline register, counters and flags.

Test Plan:
- Addi, then add: start; addi rs=0 rt=8 imm=5, then add rs=1 rt=2 rd=3 -> im_addr 0 gets 0x20080005 and im_addr 1 gets 0x00221820 on consecutive cycles; count = 2.
- Mixed formats: lui rt=1 imm=0x1234 -> 0x3C011234; j target=0x10 -> 0x08000010; bgez rs=4 imm=0xFFFE -> 0x0481FFFE; sll rd=2 rt=1 shamt=4 with rs=7 -> 0x00011100.
- Session end: finish is asserted with the last descriptor -> the word is written; cpu_hold falls exactly one cycle after that im_we; busy = 0.
- Illegal mnemonic: mnemonic 0x3F mid-stream -> err_illegal = 1; no im_we; the next legal word goes to the unskipped address.
- Memory full: with IM_AW = 2, send 5 descriptors -> 4 writes at addresses 0-3; in_ready = 0 afterwards; err_full = 1.
- Reset mid-session: rst asserted during back-to-back writes -> no further im_we; outputs return to reset values; cpu_hold = 1.
